// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// Includes the load-use hit predicate used by the control FSM.
package pipeline_hazard_pkg;

   typedef enum logic [1:0] {
      HZ_RUN       = 2'd0,
      HZ_LU_BUBBLE = 2'd1,
      HZ_MDU_WAIT  = 2'd2,
      HZ_MEM_WAIT  = 2'd3
   } hz_state_e;

   localparam int         HZ_LU_BUBBLES_MAX = 3;
   localparam logic [4:0] HZ_REG_ZERO       = 5'd0;

   function automatic logic hz_lu_hit(input logic       load,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       use1,
                                      input logic       use2);
      return load && (rd != HZ_REG_ZERO) &&
             ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Bank of N saturating event counters, one increment per cycle per asserted bit.
module hazard_perf_cnt #(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        inc,
   output logic [N-1:0][W-1:0] cnt
);

   for (genvar gi = 0; gi < N; gi++) begin : g_cnt
      logic [W-1:0] cnt_reg;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_reg <= '0;
         end else if (inc[gi] && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
         end
      end

      assign cnt[gi] = cnt_reg;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/bubble scheduler for the 6-stage pipeline (load-use, MDU, memory wait, redirect).
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import pipeline_hazard_pkg::*;
#(
   parameter int LU_BUBBLES  = 2,
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1_IDC,
   input  logic [4:0] rs2_IDC,
   input  logic       is_rs1_used,
   input  logic       is_rs2_used,
   input  logic [4:0] rd_IDR,
   input  logic       load_IDR,
   input  logic       mdu_issue,
   input  logic       mdu_done,
   input  logic       mem_req,
   input  logic       mem_ready,
   input  logic       redirect,
   output logic       stall_if,
   output logic       stall_idc,
   output logic       stall_idr,
   output logic       stall_ex,
   output logic       stall_mem,
   output logic       nop_idr,
   output logic       flush_idc,
   output logic       flush_idr,
   output logic [1:0] hz_state,
   output logic       mdu_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cnt_lu,
   output logic [CNT_W-1:0] cnt_mdu,
   output logic [CNT_W-1:0] cnt_mem,
   output logic [CNT_W-1:0] cnt_flush
`endif
);

   localparam int              MC_W     = $clog2(MDU_TIMEOUT);
   localparam logic [1:0]      LU_INIT  = 2'(LU_BUBBLES - 1);
   localparam logic [MC_W-1:0] MDU_LAST = MC_W'(MDU_TIMEOUT - 1);

   hz_state_e       state_reg, state_next;
   logic [1:0]      lu_cnt_reg, lu_cnt_next;
   logic [MC_W-1:0] mdu_cnt_reg, mdu_cnt_next;
   logic            mdu_pend_reg, mdu_pend_next;
   logic            mdu_err_reg, mdu_err_next;
   logic            mem_stall, lu_hit, run_eval, mdu_hold;

   assign mem_stall = mem_req & ~mem_ready;
   assign lu_hit    = hz_lu_hit(load_IDR, rd_IDR, rs1_IDC, rs2_IDC, is_rs1_used, is_rs2_used);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= HZ_RUN;
         lu_cnt_reg   <= '0;
         mdu_cnt_reg  <= '0;
         mdu_pend_reg <= 1'b0;
         mdu_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lu_cnt_reg   <= lu_cnt_next;
         mdu_cnt_reg  <= mdu_cnt_next;
         mdu_pend_reg <= mdu_pend_next;
         mdu_err_reg  <= mdu_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      lu_cnt_next   = lu_cnt_reg;
      mdu_cnt_next  = mdu_cnt_reg;
      mdu_pend_next = mdu_pend_reg;
      mdu_err_next  = mdu_err_reg;
      stall_if      = 1'b0;
      stall_idc     = 1'b0;
      stall_idr     = 1'b0;
      stall_ex      = 1'b0;
      stall_mem     = 1'b0;
      nop_idr       = 1'b0;
      flush_idc     = 1'b0;
      flush_idr     = 1'b0;
      run_eval      = 1'b0;
      mdu_hold      = 1'b0;

      if (mem_stall) begin
         // Whole pipe frozen; a bubble sequence in progress simply pauses in place.
         {stall_if, stall_idc, stall_idr, stall_ex, stall_mem} = 5'b11111;
         case (state_reg)
            HZ_RUN: begin
               state_next    = HZ_MEM_WAIT;
               mdu_pend_next = 1'b0;
            end
            HZ_MDU_WAIT: begin
               state_next    = HZ_MEM_WAIT;
               mdu_pend_next = ~mdu_done;
            end
            HZ_MEM_WAIT: mdu_pend_next = mdu_pend_reg & ~mdu_done;
            default: ;
         endcase
      end else begin
         case (state_reg)
            HZ_RUN: run_eval = 1'b1;
            HZ_LU_BUBBLE: begin
               if (redirect) begin
                  flush_idc   = 1'b1;
                  flush_idr   = 1'b1;
                  lu_cnt_next = '0;
                  state_next  = HZ_RUN;
               end else begin
                  stall_if    = 1'b1;
                  stall_idc   = 1'b1;
                  nop_idr     = 1'b1;
                  lu_cnt_next = lu_cnt_reg - 2'd1;
                  if (lu_cnt_reg == 2'd1) state_next = HZ_RUN;
               end
            end
            HZ_MDU_WAIT: begin
               if (mdu_done) begin
                  run_eval = 1'b1;
               end else begin
                  mdu_hold = 1'b1;
                  if (mdu_cnt_reg == MDU_LAST) begin
                     mdu_err_next = 1'b1;
                     mdu_cnt_next = '0;
                     state_next   = HZ_RUN;
                  end else begin
                     mdu_cnt_next = mdu_cnt_reg + MC_W'(1);
                  end
               end
            end
            default: begin
               // Memory released: resume the MDU wait only if its result is still outstanding.
               if (mdu_pend_reg && !mdu_done) begin
                  mdu_hold   = 1'b1;
                  state_next = HZ_MDU_WAIT;
               end else begin
                  run_eval = 1'b1;
               end
            end
         endcase

         if (mdu_hold) begin
            {stall_if, stall_idc, stall_idr, stall_ex} = 4'b1111;
         end

         if (run_eval) begin
            state_next    = HZ_RUN;
            mdu_pend_next = 1'b0;
            if (mdu_issue) begin
               state_next   = HZ_MDU_WAIT;
               mdu_cnt_next = '0;
            end else if (redirect) begin
               flush_idc = 1'b1;
               flush_idr = 1'b1;
            end else if (lu_hit) begin
               stall_if    = 1'b1;
               stall_idc   = 1'b1;
               nop_idr     = 1'b1;
               lu_cnt_next = LU_INIT;
               if (LU_BUBBLES > 1) state_next = HZ_LU_BUBBLE;
            end
         end
      end

      if (!reset) begin
         {stall_if, stall_idc, stall_idr, stall_ex, stall_mem} = 5'b00000;
         {nop_idr, flush_idc, flush_idr} = 3'b000;
      end
   end

   assign hz_state = state_reg;
   assign mdu_err  = mdu_err_reg;

`ifdef HAZARD_PERF_CNT_EN
   logic [3:0]            perf_inc;
   logic [3:0][CNT_W-1:0] perf_cnt;

   assign perf_inc = {flush_idr, stall_mem, stall_ex & ~stall_mem, nop_idr};

   hazard_perf_cnt #(.N(4), .W(CNT_W)) u_perf (
      .clk   (clk),
      .reset (reset),
      .inc   (perf_inc),
      .cnt   (perf_cnt)
   );

   assign cnt_lu    = perf_cnt[0];
   assign cnt_mdu   = perf_cnt[1];
   assign cnt_mem   = perf_cnt[2];
   assign cnt_flush = perf_cnt[3];
`else
   // Counter width only matters when the perf bank is built.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule
